seven_seg_scan: RTL



---
 rtl/seven_seg_scan.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan.sv
`timescale 1ns / 1ps
// Time-multiplexed driver for an eight-digit common-anode seven-segment display.
// Inputs are snapshotted once per frame; each digit slot opens with a blanking gap.
module seven_seg_scan #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZB          = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] bcd_digits,
  input  logic [7:0]  dp_mask,
  input  logic        enable,
  output logic [7:0]  SevenSegAn,
  output logic [6:0]  SevenSegCat,
  output logic        dp,
  output logic [2:0]  digit_idx,
  output logic        frame_tick
);

  localparam int             CW        = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_DRIVE = CW'(BLANK_CYCLES);
  localparam logic [6:0]     CAT_OFF   = 7'h7F;
  localparam logic [7:0]     AN_OFF    = 8'hFF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          run_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          frame_start;

  logic [31:0]   snap_digits_q;
  logic [7:0]    snap_dp_q;
  logic [7:0]    lz_blank;

  logic [7:0]    an_q, an_d;
  logic [6:0]    cat_q, cat_d;
  logic          dp_q, dp_d;
  logic          frame_tick_q;

  // Active-low glyphs ordered {g,f,e,d,c,b,a}; non-decimal codes go dark.
  function automatic logic [6:0] decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = CAT_OFF;
    endcase
    return seg;
  endfunction

  // cnt_q/idx_q describe the slot position visible in the current cycle.
  // Out of reset the first edge lands on position (0,0) rather than advancing.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!run_q) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign frame_start = (cnt_d == '0) && (idx_d == '0);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset_n) begin
      state_q <= ST_BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: BLANK until cnt reaches BLANK_CYCLES, DRIVE until the slot wraps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_d == CNT_DRIVE) state_d = ST_DRIVE;
      ST_DRIVE: if (cnt_d == '0)        state_d = ST_BLANK;
    endcase
    if (!run_q) state_d = ST_BLANK;
  end

  // Leading-zero mask: digit i is dark when it and everything left of it is zero with no dp.
  always_comb begin
    logic zero_above;
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      zero_above  = zero_above && (snap_digits_q[4*i +: 4] == 4'd0) && !snap_dp_q[i];
      lz_blank[i] = zero_above && (LZB == 1);
    end
  end

  // Output logic, computed for the cycle the next edge enters so the outputs register with no lag.
  // BLANK_CYCLES >= 1 guarantees the snapshot has settled before any DRIVE cycle reads it.
  always_comb begin
    an_d  = AN_OFF;
    cat_d = CAT_OFF;
    dp_d  = 1'b1;
    if (state_d == ST_DRIVE) begin
      if (enable) begin
        an_d = ~(8'd1 << idx_d);
      end
      if (!lz_blank[idx_d]) begin
        cat_d = decode(snap_digits_q[{idx_d, 2'b00} +: 4]);
        dp_d  = ~snap_dp_q[idx_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_q         <= 1'b0;
      cnt_q         <= '0;
      idx_q         <= '0;
      // NOTE: the snapshot is a handful of flops, not a RAM, so clearing it on reset is cheap and defined.
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      an_q          <= AN_OFF;
      cat_q         <= CAT_OFF;
      dp_q          <= 1'b1;
      frame_tick_q  <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      cat_q        <= cat_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_start;
      if (frame_start) begin
        snap_digits_q <= bcd_digits;
        snap_dp_q     <= dp_mask;
      end
    end
  end

  assign SevenSegAn  = an_q;
  assign SevenSegCat = cat_q;
  assign dp          = dp_q;
  assign digit_idx   = idx_q;
  assign frame_tick  = frame_tick_q;

endmodule
